memo_trans_ctrl_dp: RTL and testbench

- Control-plus-datapath core of the memory-transfer unit: sequences 8 writes into memory A, then 8 reads from A with pairwise write-back into memory B.
- Comprises three functions:
  - Controller: a counter with decoded strobes IncA, WEA, IncB, WEB.
  - Adder: ADDOut = DOut1 + DOut2.
  - Comparator: Sign = DOut1 < DOut2.
- Sits between the external memories (MC_A, MC_B), the DOut delay flop and the subtractor.

---
 rtl/memo_trans_pkg.sv | 28 ++
 rtl/memo_trans_alu.sv | 16 +
 rtl/memo_trans_ctrl_dp.sv | 79 +++++++
 tb/tb_memo_trans_ctrl_dp.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/memo_trans_pkg.sv
// Shared defaults, step constants and phase decode for the memory-transfer control/datapath core.
package memo_trans_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_WORDS_A = 8;
    localparam int DEF_CNT_W   = 5;

    localparam int WR_FIRST  = 0;
    localparam int RD_FIRST  = DEF_WORDS_A;
    localparam int DONE_STEP = 2 * DEF_WORDS_A;

    typedef enum logic [1:0] {
        PH_WRITE = 2'd0,
        PH_READ  = 2'd1,
        PH_DONE  = 2'd2
    } phase_t;

    // Anything at or past 2*words counts as DONE so an out-of-range count never strobes.
    function automatic phase_t step_phase(input int unsigned step, input int unsigned words);
        if (step < words)
            return PH_WRITE;
        else if (step < 2 * words)
            return PH_READ;
        else
            return PH_DONE;
    endfunction

endpackage

// File: rtl/memo_trans_alu.sv
// Combinational pair adder (carry discarded) and unsigned less-than comparator.
import memo_trans_pkg::*;

module memo_trans_alu #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] DOut1,
    input  logic [DATA_W-1:0] DOut2,
    output logic [DATA_W-1:0] ADDOut,
    output logic              Sign
);

    assign ADDOut = DOut1 + DOut2;
    assign Sign   = (DOut1 < DOut2);

endmodule

// File: rtl/memo_trans_ctrl_dp.sv
// Memory-transfer sequencer: 8 writes into A, 8 reads from A with pairwise write-back into B.
// Optional macro MEMO_AUTO_RESTART_EN: counter wraps from DONE back to 0 instead of saturating.
//
// phase    | meaning
// PH_WRITE | counter 0..WORDS_A-1, write A and advance its address
// PH_READ  | counter WORDS_A..2*WORDS_A-1, read A; odd steps write pair sum into B
// PH_DONE  | counter 2*WORDS_A, all strobes idle, Done asserted
import memo_trans_pkg::*;

module memo_trans_ctrl_dp #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int WORDS_A = DEF_WORDS_A,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DOut1,
    input  logic [DATA_W-1:0] DOut2,
    output logic              IncA,
    output logic              WEA,
    output logic              IncB,
    output logic              WEB,
    output logic [CNT_W-1:0]  counter,
    output logic              Done,
    output logic [DATA_W-1:0] ADDOut,
    output logic              Sign
);

    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(2 * WORDS_A);

    phase_t phase;

    always_ff @(posedge clock) begin
        if (Reset)
            counter <= '0;
        else if (counter < DONE_CNT)
            counter <= counter + CNT_W'(1);
        else begin
`ifdef MEMO_AUTO_RESTART_EN
            counter <= '0;
`else
            counter <= DONE_CNT;
`endif
        end
    end

    assign phase = step_phase(32'(counter), 32'(WORDS_A));

    // Reset gates every strobe immediately, before the counter has a chance to clear.
    always_comb begin
        IncA = 1'b0;
        WEA  = 1'b0;
        IncB = 1'b0;
        WEB  = 1'b0;
        Done = 1'b0;
        if (!Reset) begin
            case (phase)
                PH_WRITE: begin
                    IncA = 1'b1;
                    WEA  = 1'b1;
                end
                PH_READ: begin
                    IncA = 1'b1;
                    IncB = counter[0];
                    WEB  = counter[0];
                end
                default: Done = 1'b1;
            endcase
        end
    end

    memo_trans_alu #(.DATA_W(DATA_W)) u_alu (
        .DOut1  (DOut1),
        .DOut2  (DOut2),
        .ADDOut (ADDOut),
        .Sign   (Sign)
    );

endmodule

// File: tb/tb_memo_trans_ctrl_dp.sv
// Directed self-checking bench for memo_trans_ctrl_dp (honours MEMO_AUTO_RESTART_EN if defined).
module tb_memo_trans_ctrl_dp;

    logic       clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] DOut1 = 8'd0;
    logic [7:0] DOut2 = 8'd0;
    logic       IncA, WEA, IncB, WEB, Done, Sign;
    logic [4:0] counter;
    logic [7:0] ADDOut;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_a [8];
    int         web_pulses;
    logic [7:0] exp_sum;

    memo_trans_ctrl_dp dut (
        .clock   (clock),
        .Reset   (Reset),
        .DOut1   (DOut1),
        .DOut2   (DOut2),
        .IncA    (IncA),
        .WEA     (WEA),
        .IncB    (IncB),
        .WEB     (WEB),
        .counter (counter),
        .Done    (Done),
        .ADDOut  (ADDOut),
        .Sign    (Sign)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_strobes(input string tag, input logic ia, input logic wa,
                                 input logic ib, input logic wb, input logic dn);
        check({tag, " IncA"}, 32'(IncA), 32'(ia));
        check({tag, " WEA"},  32'(WEA),  32'(wa));
        check({tag, " IncB"}, 32'(IncB), 32'(ib));
        check({tag, " WEB"},  32'(WEB),  32'(wb));
        check({tag, " Done"}, 32'(Done), 32'(dn));
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic alu_vec(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] sum, input logic sgn);
        DOut1 = a;
        DOut2 = b;
        #1;
        check($sformatf("add %0d+%0d", a, b), 32'(ADDOut), 32'(sum));
        check($sformatf("sign %0d<%0d", a, b), 32'(Sign), 32'(sgn));
    endtask

    initial begin
        mem_a[0] = 8'd10;  mem_a[1] = 8'd20;
        mem_a[2] = 8'd200; mem_a[3] = 8'd100;
        mem_a[4] = 8'd7;   mem_a[5] = 8'd7;
        mem_a[6] = 8'd0;   mem_a[7] = 8'd255;

        // Arithmetic vectors, independent of the sequencer
        alu_vec(8'd2,   8'd1,   8'd3,   1'b0);
        alu_vec(8'd1,   8'd2,   8'd3,   1'b1);
        alu_vec(8'd200, 8'd100, 8'd44,  1'b0);
        alu_vec(8'd7,   8'd7,   8'd14,  1'b0);
        alu_vec(8'd0,   8'd255, 8'd255, 1'b1);

        // Bring the counter to 11 first
        tick;
        Reset = 1'b0;
        #1;
        check("first step counter", 32'(counter), 32'd0);
        for (int i = 0; i < 11; i++) tick;
        check("pre-reset counter", 32'(counter), 32'd11);
        check_strobes("step11", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Mid-sequence reset: strobes drop combinationally, counter clears on edge
        Reset = 1'b1;
        #1;
        check("reset same-cycle counter", 32'(counter), 32'd11);
        check_strobes("reset same-cycle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 2; e++) begin
            tick;
            check($sformatf("reset edge%0d counter", e), 32'(counter), 32'd0);
            check_strobes($sformatf("reset edge%0d", e), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Full clean sequence
        Reset = 1'b0;
        web_pulses = 0;
        for (int i = 0; i < 16; i++) begin
            if (i >= 8) begin
                DOut1 = mem_a[i-8];
                DOut2 = (i > 8) ? mem_a[i-9] : 8'd0;
            end
            #1;
            check($sformatf("seq counter@%0d", i), 32'(counter), 32'(i));
            if (i < 8)
                check_strobes($sformatf("write%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            else
                check_strobes($sformatf("read%0d", i), 1'b1, 1'b0, 1'b1 & i[0], 1'b1 & i[0], 1'b0);
            if (WEB) web_pulses++;
            if (i >= 8 && i[0]) begin
                exp_sum = mem_a[i-8] + mem_a[i-9];
                check($sformatf("pair sum@%0d", i), 32'(ADDOut), 32'(exp_sum));
                check($sformatf("pair sign@%0d", i), 32'(Sign), 32'(mem_a[i-8] < mem_a[i-9]));
            end
            tick;
        end
        check("web pulse count", 32'(web_pulses), 32'd4);

        check("done counter", 32'(counter), 32'd16);
        check_strobes("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef MEMO_AUTO_RESTART_EN
        tick;
        check("restart counter", 32'(counter), 32'd0);
        check_strobes("restart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        for (int e = 0; e < 10; e++) begin
            tick;
            check($sformatf("hold%0d counter", e), 32'(counter), 32'd16);
            check_strobes($sformatf("hold%0d", e), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
`endif

        // Reset while in DONE also clears Done immediately
        Reset = 1'b1;
        #1;
        check("reset in done Done", 32'(Done), 32'd0);
        tick;
        check("reset in done counter", 32'(counter), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
